// File: rtl/demux8_stream.sv
// -----------------------------------------------------------------------------
// demux8_stream
//
// Registered 1-to-8 stream demultiplexer. A single valid/ready input carries a
// data word and a 3-bit destination select. The word is registered and then
// presented on exactly one of eight valid/ready output channels. The output
// channels share one data bus. Latency is one cycle. With a ready consumer the
// block moves one word per cycle, including back-to-back words that go to
// different channels.
//
// Build option:
//   DEMUX8_STREAM_SKID_EN  undefined : a single entry (EMPTY/FULL). in_ready_o
//                                      is combinational from out_ready_i.
//                          defined   : adds a second skid entry and a SKID
//                                      state. in_ready_o is a flop output, so
//                                      no out_ready_i -> in_ready_o path exists.
//
// Ports:
//   clk_i        in   1       clock; all state changes on the rising edge
//   reset_n_i    in   1       asynchronous active-low reset
//   in_valid_i   in   1       input word valid
//   in_ready_o   out  1       block can accept an input word this cycle
//   in_sel_i     in   3       destination channel 0..7
//   in_data_i    in   DATA_W  input word
//   out_valid_o  out  8       one-hot (or zero) per-channel valid
//   out_ready_i  in   8       per-channel consumer ready
//   out_data_o   out  DATA_W  held word, shared by all channels
// -----------------------------------------------------------------------------
module demux8_stream #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_sel_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [7:0]        out_valid_o,
    input  logic [7:0]        out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;

`ifdef DEMUX8_STREAM_SKID_EN
    logic [2:0]          skid_sel_q, skid_sel_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                in_ready_q;
`endif

    logic                valid;
    logic                in_xfer;
    logic                out_xfer;

    // The main register is valid in both FULL and SKID. In SKID the skid
    // entry sits behind it.
    assign valid    = (state_q != ST_EMPTY);
    // out_ready_i is looked up only at the held select, so every other
    // channel's ready is ignored.
    assign out_xfer = valid && out_ready_i[sel_q];

`ifdef DEMUX8_STREAM_SKID_EN
    assign in_ready_o = in_ready_q;
`else
    // A word can enter when the block is empty, or when the held word leaves
    // on this same edge.
    assign in_ready_o = !valid || out_ready_i[sel_q];
`endif

    assign in_xfer = in_valid_i && in_ready_o;

    assign out_valid_o = valid ? (8'd1 << sel_q) : 8'd0;
    assign out_data_o  = data_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
`ifdef DEMUX8_STREAM_SKID_EN
        skid_sel_d  = skid_sel_q;
        skid_data_d = skid_data_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_FULL;
                    sel_d   = in_sel_i;
                    data_d  = in_data_i;
                end
            end
            ST_FULL: begin
                if (out_xfer && in_xfer) begin
                    // Pop and push on the same edge. The new word replaces
                    // the old one, so no bubble is inserted.
                    sel_d  = in_sel_i;
                    data_d = in_data_i;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
`ifdef DEMUX8_STREAM_SKID_EN
                end else if (in_xfer) begin
                    // The consumer stalled but the input was already granted.
                    // Park the word behind the main entry.
                    state_d     = ST_SKID;
                    skid_sel_d  = in_sel_i;
                    skid_data_d = in_data_i;
`endif
                end
            end
`ifdef DEMUX8_STREAM_SKID_EN
            ST_SKID: begin
                // in_ready is low here. The skid word only ever advances into
                // the main register, which keeps FIFO order.
                if (out_xfer) begin
                    state_d = ST_FULL;
                    sel_d   = skid_sel_q;
                    data_d  = skid_data_q;
                end
            end
`endif
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_EMPTY;
            sel_q   <= 3'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX8_STREAM_SKID_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            skid_sel_q  <= 3'd0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            skid_sel_q  <= skid_sel_d;
            skid_data_q <= skid_data_d;
            // Ready is registered from the next state, so it drops on the
            // same edge that fills the skid entry.
            in_ready_q  <= (state_d != ST_SKID);
        end
    end
`endif

endmodule
